// File: rtl/lock_sequencer_if.sv
// Keypad/checker-facing bundle of the lock sequencer. The slave modport is the
// sequencer's view; the master modport is the keypad/checker side.
interface lock_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       chk_correct;
    logic [1:0] compare_type;
    logic       read_input;
    logic       store_n;
    logic       unlocked;
    logic       alarm;
    logic       err_pulse;
    logic [3:0] fail_count;
    logic [2:0] state_dbg;

    modport master (
        output key_valid, key_code, chk_correct,
        input  compare_type, read_input, store_n, unlocked, alarm,
               err_pulse, fail_count, state_dbg
    );

    modport slave (
        input  key_valid, key_code, chk_correct,
        output compare_type, read_input, store_n, unlocked, alarm,
               err_pulse, fail_count, state_dbg
    );
endinterface

// File: rtl/lock_sequencer.sv
// Top-level digital-lock control FSM: drives the code checker, counts failures, runs lockout/PUK.
// Optional auto-relock of OPEN after an idle period: define LOCK_SEQUENCER_RELOCK_TIMER_EN.
module lock_sequencer #(
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 12000000,
    parameter int OPEN_CYCLES    = 60000000,
    parameter int STORE_PULSE    = 2,
    parameter int CNT_W          = 26
) (
    input logic             hwclk,
    input logic             rst_n,
    lock_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_LOCKED      = 3'd0,
        ST_OPEN        = 3'd1,
        ST_NEW_ENTER   = 3'd2,
        ST_NEW_CONFIRM = 3'd3,
        ST_COMMIT      = 3'd4,
        ST_LOCKOUT     = 3'd5,
        ST_PUK         = 3'd6
    } state_e;

    localparam logic [3:0] KEY_CLEAR  = 4'd7;
    localparam logic [3:0] KEY_ENTER  = 4'd8;
    localparam logic [3:0] KEY_CHANGE = 4'd9;
    localparam logic [3:0] FAIL_MAX   = 4'(MAX_FAIL);

    localparam int CNT_TOP_A = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int CNT_TOP_I = ((CNT_TOP_A > STORE_PULSE) ? CNT_TOP_A : STORE_PULSE) - 1;

    localparam logic [CNT_W-1:0] CNT_TOP      = CNT_W'(CNT_TOP_I);
    localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STORE_LAST   = CNT_W'(STORE_PULSE - 1);
`ifdef LOCK_SEQUENCER_RELOCK_TIMER_EN
    localparam logic [CNT_W-1:0] OPEN_LAST    = CNT_W'(OPEN_CYCLES - 1);
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       fail_q, fail_d;
    logic             err_q, err_d;
    logic [1:0]       cmp_q, cmp_d;
    logic             read_q, read_d;
    logic             store_n_q, store_n_d;
    logic             unl_q, unl_d;
    logic             alarm_q, alarm_d;

    logic             keyEnter, keyClear, keyChange, countEn, countClr;

    assign keyEnter  = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign keyClear  = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign keyChange = bus.key_valid && (bus.key_code == KEY_CHANGE);

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        err_d    = 1'b0;
        countEn  = 1'b0;
        countClr = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (keyEnter) begin
                    if (bus.chk_correct) begin
                        state_d = ST_OPEN;
                        fail_d  = 4'd0;
                    end else begin
                        err_d  = 1'b1;
                        fail_d = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 4'd1;
                        if (fail_d == FAIL_MAX) begin
                            state_d = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (keyClear) begin
                    state_d = ST_LOCKED;
                end else if (keyChange) begin
                    state_d = ST_NEW_ENTER;
                end
`ifdef LOCK_SEQUENCER_RELOCK_TIMER_EN
                // Any key press restarts the idle window before relocking.
                else if (bus.key_valid) begin
                    countClr = 1'b1;
                end else if (cnt_q == OPEN_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    countEn = 1'b1;
                end
`endif
            end
            ST_NEW_ENTER: begin
                if (keyEnter) begin
                    state_d = ST_NEW_CONFIRM;
                end else if (keyClear) begin
                    state_d = ST_OPEN;
                end
            end
            ST_NEW_CONFIRM: begin
                if (keyEnter) begin
                    if (bus.chk_correct) begin
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_OPEN;
                    end
                end else if (keyClear) begin
                    state_d = ST_OPEN;
                end
            end
            ST_COMMIT: begin
                countEn = 1'b1;
                if (cnt_q == STORE_LAST) begin
                    state_d = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                countEn = 1'b1;
                if (cnt_q == LOCKOUT_LAST) begin
                    state_d = ST_PUK;
                end
            end
            ST_PUK: begin
                if (keyEnter) begin
                    if (bus.chk_correct) begin
                        state_d = ST_OPEN;
                        fail_d  = 4'd0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_LOCKOUT;
                    end
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase

        // Shared counter restarts on every state change and saturates rather than wrapping.
        if (state_d != state_q || countClr) begin
            cnt_d = '0;
        end else if (countEn && cnt_q != CNT_TOP) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs are decoded from the next state so they land in registers with the state.
    always_comb begin
        cmp_d     = 2'b01;
        read_d    = 1'b1;
        unl_d     = 1'b0;
        alarm_d   = 1'b0;
        store_n_d = 1'b1;
        case (state_d)
            ST_LOCKED:      begin cmp_d = 2'b01; read_d = 1'b1; end
            ST_OPEN:        begin cmp_d = 2'b01; read_d = 1'b1; unl_d = 1'b1; end
            ST_NEW_ENTER:   begin cmp_d = 2'b11; read_d = 1'b1; unl_d = 1'b1; end
            ST_NEW_CONFIRM: begin cmp_d = 2'b10; read_d = 1'b1; unl_d = 1'b1; end
            ST_COMMIT:      begin cmp_d = 2'b10; read_d = 1'b0; unl_d = 1'b1; store_n_d = 1'b0; end
            ST_LOCKOUT:     begin cmp_d = 2'b00; read_d = 1'b0; alarm_d = 1'b1; end
            ST_PUK:         begin cmp_d = 2'b00; read_d = 1'b1; end
            default:        begin cmp_d = 2'b01; read_d = 1'b1; end
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_q   <= ST_LOCKED;
            cnt_q     <= '0;
            fail_q    <= 4'd0;
            err_q     <= 1'b0;
            cmp_q     <= 2'b01;
            read_q    <= 1'b1;
            store_n_q <= 1'b1;
            unl_q     <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            cmp_q     <= cmp_d;
            read_q    <= read_d;
            store_n_q <= store_n_d;
            unl_q     <= unl_d;
            alarm_q   <= alarm_d;
        end
    end

    assign bus.compare_type = cmp_q;
    assign bus.read_input   = read_q;
    assign bus.store_n      = store_n_q;
    assign bus.unlocked     = unl_q;
    assign bus.alarm        = alarm_q;
    assign bus.err_pulse    = err_q;
    assign bus.fail_count   = fail_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: scripted test-plan scenarios plus randomized keys,
// all checked every cycle against a behavioural model of the lock.
module tb_lock_sequencer;

    localparam int MAX_FAIL       = 3;
    localparam int LOCKOUT_CYCLES = 16;
    localparam int OPEN_CYCLES    = 32;
    localparam int STORE_PULSE    = 2;

    logic hwclk = 1'b0;
    logic rst_n;
    lock_sequencer_if bus();

    lock_sequencer #(
        .MAX_FAIL      (MAX_FAIL),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .OPEN_CYCLES   (OPEN_CYCLES),
        .STORE_PULSE   (STORE_PULSE),
        .CNT_W         (8)
    ) dut (
        .hwclk(hwclk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 hwclk = ~hwclk;

    int nVectors = 0;
    int nMiscompares = 0;
    bit checkEn = 1'b0;

    // Per-state output tables, indexed by the state number.
    int cmpTab[7]   = '{1, 1, 3, 2, 2, 0, 0};
    int readTab[7]  = '{1, 1, 1, 1, 0, 0, 1};
    int unlTab[7]   = '{0, 1, 1, 1, 1, 0, 0};
    int alarmTab[7] = '{0, 0, 0, 0, 0, 1, 0};

    int mState = 0;
    int mFails = 0;
    int mDwell = 0;
    bit mErr   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural lock: which state it is in, how long it has dwelt there, how many misses.
    always @(posedge hwclk) begin
        int nxt;
        bit ent, clr, chg;
        mErr = 1'b0;
        if (!rst_n) begin
            mState = 0;
            mFails = 0;
            mDwell = 0;
        end else begin
            nxt = mState;
            ent = bus.key_valid && bus.key_code == 4'd8;
            clr = bus.key_valid && bus.key_code == 4'd7;
            chg = bus.key_valid && bus.key_code == 4'd9;
            case (mState)
                0: if (ent) begin
                    if (bus.chk_correct) begin nxt = 1; mFails = 0; end
                    else begin
                        mErr = 1'b1;
                        mFails = (mFails + 1 > MAX_FAIL) ? MAX_FAIL : mFails + 1;
                        if (mFails == MAX_FAIL) nxt = 5;
                    end
                end
                1: begin
                    if (clr) nxt = 0;
                    else if (chg) nxt = 2;
`ifdef LOCK_SEQUENCER_RELOCK_TIMER_EN
                    else if (!bus.key_valid && mDwell + 1 == OPEN_CYCLES) nxt = 0;
`endif
                end
                2: if (ent) nxt = 3; else if (clr) nxt = 1;
                3: if (ent) begin
                    if (bus.chk_correct) nxt = 4;
                    else begin mErr = 1'b1; nxt = 1; end
                end else if (clr) nxt = 1;
                4: if (mDwell + 1 == STORE_PULSE) nxt = 1;
                5: if (mDwell + 1 == LOCKOUT_CYCLES) nxt = 6;
                6: if (ent) begin
                    if (bus.chk_correct) begin nxt = 1; mFails = 0; end
                    else begin mErr = 1'b1; nxt = 5; end
                end
                default: nxt = 0;
            endcase
            if (nxt != mState) mDwell = 0;
            else if (mState == 1 && bus.key_valid) mDwell = 0;
            else mDwell++;
            mState = nxt;
        end
    end

    // Single compare process: every output against the model on every cycle.
    always @(negedge hwclk) begin
        if (checkEn) begin
            checkOutput("state_dbg", 32'(bus.state_dbg), 32'(mState));
            checkOutput("compare_type", 32'(bus.compare_type), 32'(cmpTab[mState]));
            checkOutput("read_input", 32'(bus.read_input), 32'(readTab[mState]));
            checkOutput("unlocked", 32'(bus.unlocked), 32'(unlTab[mState]));
            checkOutput("alarm", 32'(bus.alarm), 32'(alarmTab[mState]));
            checkOutput("store_n", 32'(bus.store_n), (mState == 4) ? 32'd0 : 32'd1);
            checkOutput("err_pulse", 32'(bus.err_pulse), 32'(mErr));
            checkOutput("fail_count", 32'(bus.fail_count), 32'(mFails));
        end
    end

    // Present one key for one sampling edge; returns 3 time units after that edge.
    task automatic applyStimulus(input logic kv, input logic [3:0] code, input logic chk);
        bus.key_valid   = kv;
        bus.key_code    = code;
        bus.chk_correct = chk;
        @(posedge hwclk);
        #3;
        bus.key_valid   = 1'b0;
        bus.chk_correct = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #3;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.key_valid   = 1'b0;
        bus.key_code    = 4'd0;
        bus.chk_correct = 1'b0;
        @(posedge hwclk);
        #3;
        checkEn = 1'b1;
        idleCycles(1);
        checkOutput("rst_state", 32'(bus.state_dbg), 32'd0);
        checkOutput("rst_cmp", 32'(bus.compare_type), 32'd1);
        checkOutput("rst_store_n", 32'(bus.store_n), 32'd1);
        rst_n = 1'b1;

        // Digits then a correct enter unlocks.
        for (int d = 1; d <= 6; d++) applyStimulus(1'b1, 4'(d), 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b1);
        checkOutput("unlock_unlocked", 32'(bus.unlocked), 32'd1);
        checkOutput("unlock_state", 32'(bus.state_dbg), 32'd1);
        checkOutput("unlock_fails", 32'(bus.fail_count), 32'd0);
        applyStimulus(1'b1, 4'd7, 1'b0);
        checkOutput("relock_state", 32'(bus.state_dbg), 32'd0);

        // Three wrong entries lead into lockout.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 4'd8, 1'b0);
            checkOutput("wrong_err", 32'(bus.err_pulse), 32'd1);
            checkOutput("wrong_fails", 32'(bus.fail_count), 32'(i));
        end
        checkOutput("lockout_alarm", 32'(bus.alarm), 32'd1);
        checkOutput("lockout_cmp", 32'(bus.compare_type), 32'd0);
        applyStimulus(1'b1, 4'd8, 1'b1);
        idleCycles(14);
        checkOutput("lockout_hold", 32'(bus.state_dbg), 32'd5);
        idleCycles(1);
        checkOutput("puk_state", 32'(bus.state_dbg), 32'd6);
        checkOutput("puk_alarm", 32'(bus.alarm), 32'd0);

        // Wrong PUK returns to a full lockout; correct PUK opens and clears failures.
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("puk_err", 32'(bus.err_pulse), 32'd1);
        checkOutput("puk_back", 32'(bus.state_dbg), 32'd5);
        idleCycles(15);
        checkOutput("lockout2_hold", 32'(bus.state_dbg), 32'd5);
        idleCycles(1);
        checkOutput("puk2_state", 32'(bus.state_dbg), 32'd6);
        applyStimulus(1'b1, 4'd8, 1'b1);
        checkOutput("puk_open", 32'(bus.unlocked), 32'd1);
        checkOutput("puk_fails", 32'(bus.fail_count), 32'd0);

        // Change code: enter, confirm, commit pulse of two cycles.
        applyStimulus(1'b1, 4'd9, 1'b0);
        checkOutput("chg_cmp", 32'(bus.compare_type), 32'd3);
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("confirm_cmp", 32'(bus.compare_type), 32'd2);
        applyStimulus(1'b1, 4'd8, 1'b1);
        checkOutput("commit_store0", 32'(bus.store_n), 32'd0);
        applyStimulus(1'b1, 4'd7, 1'b0);
        checkOutput("commit_store1", 32'(bus.store_n), 32'd0);
        idleCycles(1);
        checkOutput("commit_done", 32'(bus.store_n), 32'd1);
        checkOutput("commit_open", 32'(bus.state_dbg), 32'd1);

        // Confirm mismatch.
        applyStimulus(1'b1, 4'd9, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        checkOutput("mismatch_err", 32'(bus.err_pulse), 32'd1);
        checkOutput("mismatch_open", 32'(bus.state_dbg), 32'd1);

        // Reset in the first store_n-low cycle.
        applyStimulus(1'b1, 4'd9, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b0);
        applyStimulus(1'b1, 4'd8, 1'b1);
        rst_n = 1'b0;
        idleCycles(1);
        checkOutput("rstc_store_n", 32'(bus.store_n), 32'd1);
        checkOutput("rstc_state", 32'(bus.state_dbg), 32'd0);
        checkOutput("rstc_unlocked", 32'(bus.unlocked), 32'd0);
        rst_n = 1'b1;

        // OPEN idle behaviour with and without the relock timer.
        applyStimulus(1'b1, 4'd8, 1'b1);
`ifdef LOCK_SEQUENCER_RELOCK_TIMER_EN
        idleCycles(19);
        applyStimulus(1'b1, 4'd3, 1'b0);
        idleCycles(31);
        checkOutput("relock_hold", 32'(bus.state_dbg), 32'd1);
        idleCycles(1);
        checkOutput("relock_fire", 32'(bus.state_dbg), 32'd0);
        checkOutput("relock_noerr", 32'(bus.err_pulse), 32'd0);
`else
        idleCycles(100);
        checkOutput("open_persist", 32'(bus.state_dbg), 32'd1);
`endif

        // Randomized keys, weighted toward command keys, with rare resets.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] code;
            logic kv;
            kv = ($urandom_range(0, 2) == 0);
            code = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(7, 9)) : 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 399) != 0);
            applyStimulus(kv, code, 1'($urandom_range(0, 1)));
        end
        rst_n = 1'b1;
        idleCycles(2);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Top-level control FSM for the digital lock.
- Sequences the code validity checker by driving its compare mode, its input-enable and its active-low store strobe.
- Interprets keypad command keys (7 = clear/lock, 8 = enter, 9 = change code).
- Owns the failed-attempt counter, the lockout/PUK recovery path and the unlocked/alarm outputs.

Parameters:
- MAX_FAIL, 3: consecutive wrong user-code entries before lockout (1..15).
- LOCKOUT_CYCLES, 12000000: hwclk cycles spent in LOCKOUT (1 s at 12 MHz).
- OPEN_CYCLES, 60000000: idle cycles before auto-relock (used only with RELOCK_TIMER_EN).
- STORE_PULSE, 2: cycles store_n is held low during commit (>=1).
- CNT_W, 26: width of the shared cycle counter; must hold max(LOCKOUT_CYCLES, OPEN_CYCLES).

Ports:
- hwclk, in, 1: system clock.
- rst_n, in, 1: synchronous active-low reset.
- key_valid, in, 1: one-cycle pulse, debounced key press.
- key_code, in, 4: key value, sampled when key_valid=1.
- chk_correct, in, 1: checker match flag, level, valid when key_valid=1.
- compare_type, out, 2: checker mode. 00 COMPAREPC, 01 COMPAREUC, 10 MATCHUC, 11 STOREUC.
- read_input, out, 1: 1 = checker shifts in key digits.
- store_n, out, 1: active-low commit strobe to checker; idles 1.
- unlocked, out, 1: lock actuator, 1 = open.
- alarm, out, 1: 1 while in LOCKOUT.
- err_pulse, out, 1: one-cycle pulse on wrong entry or confirm mismatch.
- fail_count, out, 4: consecutive failures, saturating at MAX_FAIL.
- state_dbg, out, 3: current state encoding.

Behaviour:
- Interface is fixed: one clock, hwclk; reset rst_n is synchronous and active-low.
- All outputs are registered. A decision on key_valid at edge N is visible after edge N.
- Reset values: LOCKED, compare_type=01, read_input=1, store_n=1, unlocked=0, alarm=0, err_pulse=0, fail_count=0, counter=0.
- Reset has priority over everything. Reset during COMMIT drives store_n to 1 at the reset edge, and the code is not committed by this block.
- Enter key (8) definition: key_valid=1 with key_code=8. Clear is code 7; change is code 9.
- Digit keys (0-6) never change state. The checker consumes them.
- State encodings: LOCKED=0, OPEN=1, NEW_ENTER=2, NEW_CONFIRM=3, COMMIT=4, LOCKOUT=5, PUK=6.
- LOCKED (cmp 01, read 1):
  - Enter with chk_correct=1: go to OPEN, fail_count <= 0.
  - Enter with chk_correct=0: err_pulse, fail_count+1. If the new count equals MAX_FAIL, go to LOCKOUT.
  - Codes 7 and 9: ignored.
- OPEN (cmp 01, read 1, unlocked=1):
  - 7: go to LOCKED.
  - 9: go to NEW_ENTER.
  - 8: ignored.
- NEW_ENTER (cmp 11, read 1, unlocked=1):
  - 8: go to NEW_CONFIRM.
  - 7: abort, go to OPEN.
- NEW_CONFIRM (cmp 10, read 1, unlocked=1):
  - 8 with chk_correct=1: go to COMMIT.
  - 8 with chk_correct=0: err_pulse, go to OPEN.
  - 7: go to OPEN.
- COMMIT (cmp 10, read 0, unlocked=1):
  - store_n=0 for exactly STORE_PULSE cycles, then store_n=1 and go to OPEN.
  - All keys ignored.
- LOCKOUT (cmp 00, read 0, alarm=1):
  - Counter counts 0..LOCKOUT_CYCLES-1, then go to PUK.
  - All keys ignored. fail_count holds MAX_FAIL.
- PUK (cmp 00, read 1, alarm=0):
  - 8 with chk_correct=1: fail_count <= 0, go to OPEN.
  - 8 with chk_correct=0: err_pulse, go to LOCKOUT (counter restarts at 0).
  - 7: ignored.
- The counter clears on every state entry. It never wraps; it stops at its terminal value.
- fail_count saturates at MAX_FAIL. It clears only on a successful unlock from LOCKED or PUK, or on reset.
- Undefined state_dbg values recover to LOCKED on the next edge.

Optional Feature:
- Macro: LOCK_SEQUENCER_RELOCK_TIMER_EN.
- Defined: in OPEN, the counter increments each cycle and clears on any key_valid. Reaching OPEN_CYCLES-1 goes to LOCKED with no err_pulse. NEW_ENTER and NEW_CONFIRM are not timed.
- Undefined: OPEN persists until key 7. The timer logic is absent.

Test Plan:
- Reset, then digits 1-6, then key 8 with chk_correct=1 -> unlocked=1 one cycle after the 8; fail_count=0; state_dbg=1.
- Three enters with chk_correct=0 (MAX_FAIL=3) -> three err_pulses; fail_count 1,2,3; alarm=1 and compare_type=00 after the third; after LOCKOUT_CYCLES (set 16), state_dbg=6 and alarm=0.
- In PUK, 8 with chk_correct=0 -> err_pulse, return to LOCKOUT for another full count. Then in PUK, 8 with chk_correct=1 -> unlocked=1, fail_count=0.
- OPEN, key 9 -> compare_type=11; key 8 -> compare_type=10; key 8 with chk_correct=1 -> store_n low exactly 2 cycles, then OPEN. Repeating with chk_correct=0 -> err_pulse, store_n never low.
- Assert rst_n=0 during the first store_n-low cycle -> store_n=1, state LOCKED, unlocked=0 after that edge; key_valid in LOCKOUT/COMMIT has no effect.
- With macro defined and OPEN_CYCLES=32: idle in OPEN -> LOCKED after 32 cycles; a key at cycle 20 restarts the count. With macro undefined, OPEN holds for 100 cycles.
